// File: rtl/synth_cfg_pkg.sv
// Shared definitions for the synth config write path: field widths,
// address-byte layout, strobe timing floors and FSM state encodings.
package synth_cfg_pkg;

  localparam int CFG_INDEX_BITS = 4;
  localparam int CFG_DATA_BITS  = 8;

  // Address byte: bit 7 enables pointer auto-increment, bits [3:0] load it.
  localparam int AUTO_INC_BIT = 7;

  // The synth needs 2 cycles of strobe synchroniser plus up to 5 override
  // retry stalls plus 1 cycle of margin before it reliably sees a level.
  localparam int STROBE_MIN_HIGH = 8;
  localparam int STROBE_MIN_LOW  = 4;

  typedef enum logic {
    RX_WAIT_ADDR,
    RX_DATA
  } rx_state_t;

  typedef enum logic [1:0] {
    STB_IDLE,
    STB_HIGH,
    STB_LOW
  } stb_state_t;

  // Byte index layout used by the synth: {word[2:0], hi_byte}.
  function automatic logic [CFG_INDEX_BITS-1:0] cfg_index_enc(
    input logic [2:0] word,
    input logic       hi_byte
  );
    return {word, hi_byte};
  endfunction

endpackage

// File: rtl/cfg_write_fifo.sv
// Small synchronous FIFO for pending config writes. Pushes while full and
// pops while empty are ignored; the read port shows the head entry, so a
// pop in the same cycle as a push always returns the older contents.
module cfg_write_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB separates full from empty when the low bits match.
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset discards everything queued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/serial_cfg_loader.sv
// SPI mode-0 receiver that turns frames of {address byte, data bytes...}
// into queued byte writes, replayed to the synth as index/data plus a
// slow strobe that survives its synchroniser and retry stalls.
module serial_cfg_loader
  import synth_cfg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int STROBE_HIGH = 12,
  parameter int STROBE_LOW  = 12,
  parameter int INDEX_BITS  = CFG_INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sck,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  cfg_strobe,
  output logic [INDEX_BITS-1:0] cfg_index,
  output logic [7:0]            cfg_data,
  output logic                  busy,
  output logic                  overflow
);

  localparam int ENTRY_W = INDEX_BITS + CFG_DATA_BITS;
  localparam int CNT_MAX = (STROBE_HIGH > STROBE_LOW) ? STROBE_HIGH : STROBE_LOW;
  localparam int CNT_W   = $clog2(CNT_MAX);

  // ---------------- input synchronisers ----------------
  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic sck_d, cs_d;
  logic sck_s, cs_s, mosi_s;
  logic sck_rise, cs_fall;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s && !sck_d;
  assign cs_fall  = !cs_s && cs_d;

  // Bring the SPI pins into clk; one extra copy of sck/cs_n for edge detect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
    end
  end

  // ---------------- frame receiver ----------------
  rx_state_t             rx_state;
  logic [2:0]            bit_cnt;
  logic [6:0]            shreg;
  logic [INDEX_BITS-1:0] ptr;
  logic                  auto_inc;
  logic [7:0]            rx_byte;
  logic                  bit_en;
  logic                  push;

  // mosi_s is aligned with sck_s, so the bit completing a byte is live here.
  assign rx_byte = {shreg, mosi_s};
  assign bit_en  = sck_rise && !cs_s && !cs_fall;
  assign push    = bit_en && (bit_cnt == 3'd7) && (rx_state == RX_DATA);

  // Shift MSB-first; deselect throws away any partial byte and restarts framing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state <= RX_WAIT_ADDR;
      bit_cnt  <= '0;
      shreg    <= '0;
      ptr      <= '0;
      auto_inc <= 1'b0;
    end else if (cs_s || cs_fall) begin
      rx_state <= RX_WAIT_ADDR;
      bit_cnt  <= '0;
    end else if (bit_en) begin
      shreg   <= rx_byte[6:0];
      bit_cnt <= bit_cnt + 3'd1;
      if (bit_cnt == 3'd7) begin
        if (rx_state == RX_WAIT_ADDR) begin
          ptr      <= rx_byte[INDEX_BITS-1:0];
          auto_inc <= rx_byte[AUTO_INC_BIT];
          rx_state <= RX_DATA;
        end else if (auto_inc) begin
          // Advances even if the write was dropped, so later bytes keep their slots.
          ptr <= ptr + INDEX_BITS'(1);
        end
      end
    end
  end

  // ---------------- write queue ----------------
  logic [ENTRY_W-1:0] head;
  logic               fifo_full, fifo_empty, pop;
  stb_state_t         stb_state;

  assign pop = (stb_state == STB_IDLE) && !fifo_empty;

  cfg_write_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({ptr, rx_byte}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Sticky drop indicator; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n)                 overflow <= 1'b0;
    else if (push && fifo_full) overflow <= 1'b1;
  end

  // ---------------- strobe sequencer ----------------
  logic [CNT_W-1:0] cnt;

  // Index/data load only when a write starts and hold through HIGH and LOW.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stb_state  <= STB_IDLE;
      cfg_strobe <= 1'b0;
      cfg_index  <= '0;
      cfg_data   <= '0;
      cnt        <= '0;
    end else begin
      case (stb_state)
        STB_IDLE: begin
          if (!fifo_empty) begin
            cfg_index  <= head[ENTRY_W-1:CFG_DATA_BITS];
            cfg_data   <= head[CFG_DATA_BITS-1:0];
            cfg_strobe <= 1'b1;
            cnt        <= CNT_W'(STROBE_HIGH - 1);
            stb_state  <= STB_HIGH;
          end
        end
        STB_HIGH: begin
          if (cnt == '0) begin
            cfg_strobe <= 1'b0;
            cnt        <= CNT_W'(STROBE_LOW - 1);
            stb_state  <= STB_LOW;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        STB_LOW: begin
          if (cnt == '0) stb_state <= STB_IDLE;
          else           cnt <= cnt - CNT_W'(1);
        end
        default: stb_state <= STB_IDLE;
      endcase
    end
  end

  // busy lags the queue/sequencer state by one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) busy <= 1'b0;
    else        busy <= !fifo_empty || (stb_state != STB_IDLE);
  end

endmodule

// File: tb/tb_serial_cfg_loader.sv
// Randomised SPI frames against a frame-level write model; a monitor
// checks each strobe against the expected write queue and its timing.
module tb_serial_cfg_loader;

  localparam int STROBE_HIGH = 12;
  localparam int STROBE_LOW  = 12;

  logic       clk, rst_n, sck, cs_n, mosi;
  logic       cfg_strobe, busy, overflow;
  logic [3:0] cfg_index;
  logic [7:0] cfg_data;

  serial_cfg_loader #(
    .SYNC_STAGES (2),
    .FIFO_DEPTH  (4),
    .STROBE_HIGH (STROBE_HIGH),
    .STROBE_LOW  (STROBE_LOW),
    .INDEX_BITS  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sck        (sck),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .cfg_strobe (cfg_strobe),
    .cfg_index  (cfg_index),
    .cfg_data   (cfg_data),
    .busy       (busy),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [11:0] exp_q [$];
  logic [7:0]  frame_q [$];
  bit          lossy = 1'b0;
  int          n_stb = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int          cyc = 0;
  int          fall_cyc = 0;
  int          hi_len = 0;
  bit          seen_rst = 1'b1;
  logic        prev_stb = 1'b0, prev_busy = 1'b0;
  logic [11:0] prev_out = '0, held = '0, req;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) seen_rst = 1'b1;
    if (cfg_strobe && !prev_stb) begin
      n_stb++;
      if (!seen_rst) begin
        check("low_len_min", 32'(cyc - fall_cyc >= STROBE_LOW + 1), 32'd1);
        check("hold_through_low", 32'(prev_out), 32'(held));
      end
      seen_rst = 1'b0;
      held     = {cfg_index, cfg_data};
      hi_len   = 1;
      if (lossy)
        while (exp_q.size() > 0 && exp_q[0] !== {cfg_index, cfg_data}) void'(exp_q.pop_front());
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write: got index=%0d data=%02h, required no write", cfg_index, cfg_data);
      end else begin
        req = exp_q.pop_front();
        check("write", 32'({cfg_index, cfg_data}), 32'(req));
      end
    end else if (cfg_strobe) begin
      hi_len++;
    end
    if (!cfg_strobe && prev_stb) begin
      if (!seen_rst) begin
        check("high_len", 32'(hi_len), 32'(STROBE_HIGH));
        check("hold_through_high", 32'({cfg_index, cfg_data}), 32'(held));
      end
      fall_cyc = cyc;
    end
    if (!busy && prev_busy && !seen_rst)
      check("busy_fall_delay", 32'(cyc - fall_cyc), 32'(STROBE_LOW + 1));
    prev_stb  = cfg_strobe;
    prev_busy = busy;
    prev_out  = {cfg_index, cfg_data};
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Frame-level model: address byte sets pointer/auto-inc, each full data byte is a write.
  task automatic model_frame(input int nfull);
    logic [3:0] p;
    logic       inc;
    if (nfull < 1) return;
    p   = frame_q[0][3:0];
    inc = frame_q[0][7];
    for (int i = 1; i < nfull; i++) begin
      exp_q.push_back({p, frame_q[i]});
      if (inc) p = p + 4'd1;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b, input int h, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      sck  = 1'b0;
      mosi = b[7-i];
      tick(h);
      sck = 1'b1;
      tick(h);
    end
    sck = 1'b0;
  endtask

  task automatic send_frame(input int h, input int trunc, input int tail);
    int nfull;
    int nb;
    nfull = (trunc > 0) ? frame_q.size() - 1 : frame_q.size();
    model_frame(nfull);
    cs_n = 1'b0;
    tick(h);
    for (int i = 0; i < frame_q.size(); i++) begin
      nb = (trunc > 0 && i == frame_q.size() - 1) ? trunc : 8;
      spi_byte(frame_q[i], h, nb);
    end
    tick(h);
    cs_n = 1'b1;
    tick(tail);
  endtask

  task automatic wait_idle(input int max, input bit need_q);
    int n;
    n = 0;
    tick(4);
    while (busy || (need_q && exp_q.size() != 0)) begin
      if (n >= max) begin
        total++; bad++;
        $display("FAIL idle_timeout: busy=%0d pending=%0d after %0d cycles, required idle", busy, exp_q.size(), n);
        return;
      end
      tick(1);
      n++;
    end
  endtask

  // ---------------- test sequence ----------------
  int base, nd, hh, sent;

  initial begin
    rst_n = 1'b0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    tick(3);
    check("rst_strobe", 32'(cfg_strobe), 32'd0);
    check("rst_index", 32'(cfg_index), 32'd0);
    check("rst_data", 32'(cfg_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // single write
    base = n_stb;
    frame_q = '{8'h03, 8'hA5};
    send_frame(4, 0, 4);
    wait_idle(300, 1);
    check("single_count", 32'(n_stb - base), 32'd1);

    // auto-increment with 15 -> 0 wrap
    base = n_stb;
    frame_q = '{8'h8E, 8'h11, 8'h22, 8'h33};
    send_frame(4, 0, 4);
    wait_idle(400, 1);
    check("autoinc_count", 32'(n_stb - base), 32'd3);

    // fixed pointer
    base = n_stb;
    frame_q = '{8'h05, 8'h01, 8'h02};
    send_frame(3, 0, 4);
    wait_idle(400, 1);
    check("fixed_count", 32'(n_stb - base), 32'd2);

    // deselect after 5 bits of the first data byte, then a clean frame
    base = n_stb;
    frame_q = '{8'h04, 8'hFF};
    send_frame(4, 5, 8);
    wait_idle(200, 1);
    check("abort_count", 32'(n_stb - base), 32'd0);
    frame_q = '{8'h02, 8'h7F};
    send_frame(4, 0, 4);
    wait_idle(300, 1);
    check("after_abort_count", 32'(n_stb - base), 32'd1);

    // address-only frame
    base = n_stb;
    frame_q = '{8'h89};
    send_frame(5, 0, 10);
    wait_idle(100, 1);
    check("addr_only_count", 32'(n_stb - base), 32'd0);

    // random legal-rate frames
    for (int f = 0; f < 8; f++) begin
      nd = $urandom_range(1, 3);
      hh = $urandom_range(3, 6);
      frame_q.delete();
      frame_q.push_back(8'($urandom));
      for (int k = 0; k < nd; k++) frame_q.push_back(8'($urandom));
      base = n_stb;
      send_frame(hh, 0, $urandom_range(4, 20));
      wait_idle(500, 1);
      check("rand_count", 32'(n_stb - base), 32'(nd));
    end
    check("no_overflow_legal", 32'(overflow), 32'd0);

    // reset while the strobe is high
    frame_q = '{8'h0A, 8'h99};
    send_frame(4, 0, 0);
    for (int i = 0; i < 40 && !cfg_strobe; i++) tick(1);
    tick(2);
    check("mid_high_before_rst", 32'(cfg_strobe), 32'd1);
    rst_n = 1'b0;
    tick(1);
    check("mid_rst_strobe", 32'(cfg_strobe), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    exp_q.delete();
    tick(2);
    base = n_stb;
    frame_q = '{8'h01, 8'h55};
    send_frame(4, 0, 4);
    wait_idle(300, 1);
    check("post_rst_count", 32'(n_stb - base), 32'd1);

    // over-rate burst: sck toggling every clk outruns the 25-cycle drain
    lossy = 1'b1;
    base  = n_stb;
    sent  = 24;
    frame_q.delete();
    frame_q.push_back(8'h83);
    for (int k = 0; k < sent; k++) frame_q.push_back(8'(8'h40 + k));
    send_frame(1, 0, 4);
    wait_idle(2000, 0);
    check("burst_overflow", 32'(overflow), 32'd1);
    check("burst_some_dropped", 32'(n_stb - base < sent), 32'd1);
    check("burst_min_writes", 32'(n_stb - base >= 5), 32'd1);
    lossy = 1'b0;
    exp_q.delete();
    frame_q = '{8'h06, 8'h3C};
    send_frame(4, 0, 4);
    wait_idle(300, 1);
    check("overflow_sticky", 32'(overflow), 32'd1);
    rst_n = 1'b0;
    tick(1);
    check("overflow_cleared", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    tick(4);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
